drive_mode_ctrl: RTL and testbench

Parametrised drive controller for the two-stepper Bluetooth car. It takes decoded UART bytes (data plus a one-cycle valid strobe) and a raw wall-sensor line. From these it drives the shared motor enable and the two per-motor direction bits that feed the stepper interfaces. It adds three things over the current top-level mode logic: a proper IDLE/MANUAL/AUTO mode register, a counted auto wall-avoidance FSM with configurable back/turn durations and alternating turn side, and a debounced wall input plus an optional manual-mode failsafe timeout.

---
 rtl/drive_mode_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_drive_mode_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_mode_ctrl.sv
// Drive mode controller for the two-stepper car: decodes command bytes into
// IDLE/MANUAL/AUTO modes, runs a counted wall-avoidance sequence in AUTO,
// debounces the wall sensor and optionally stops after a quiet spell in MANUAL.
//
// mode   | meaning
// M_IDLE   | motors disabled (STOP)
// M_MANUAL | last drive command held until STOP, AUTO or timeout
// M_AUTO   | autonomous wall avoidance, sub-state below
//
// auto   | meaning
// A_FWD  | drive forward, watch the debounced wall flag
// A_BACK | reverse for BACK_CYCLES
// A_TURN | turn toward turn side for TURN_CYCLES, then flip side
module drive_mode_ctrl #(
    parameter int          CNT_W          = 28,
    parameter int          BACK_CYCLES    = 200_000_000,
    parameter int          TURN_CYCLES    = 200_000_000,
    parameter int          WALL_DEBOUNCE  = 16,
    parameter int          MANUAL_TIMEOUT = 0,
    parameter int          ALT_TURN       = 1,
    parameter logic [7:0]  CMD_LEFT       = 8'd3,
    parameter logic [7:0]  CMD_RIGHT      = 8'd4,
    parameter logic [7:0]  CMD_STOP       = 8'd5,
    parameter logic [7:0]  CMD_AUTO       = 8'd6,
    parameter logic [7:0]  CMD_DOWN       = 8'd7,
    parameter logic [7:0]  CMD_UP         = 8'd9
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    input  logic       is_wall_raw,
    output logic       motor_en,
    output logic       motor_dir_l,
    output logic       motor_dir_r,
    output logic [1:0] mode,
    output logic [1:0] auto_state,
    output logic       wall,
    output logic       cmd_err
);

    typedef enum logic [1:0] {M_IDLE = 2'd0, M_MANUAL = 2'd1, M_AUTO = 2'd2} mode_t;
    typedef enum logic [1:0] {A_FWD = 2'd0, A_BACK = 2'd1, A_TURN = 2'd2} astate_t;

    // Motion encodings as {en, dir_l, dir_r}
    localparam logic [2:0] MOT_FWD   = 3'b101;
    localparam logic [2:0] MOT_BACK  = 3'b110;
    localparam logic [2:0] MOT_LEFT  = 3'b100;
    localparam logic [2:0] MOT_RIGHT = 3'b111;
    localparam logic [2:0] MOT_STOP  = 3'b011;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] BACK_LAST  = CNT_W'(BACK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(WALL_DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] MAN_LAST   =
        CNT_W'((MANUAL_TIMEOUT > 0) ? (MANUAL_TIMEOUT - 1) : 0);
    localparam bit               TIMEOUT_EN = (MANUAL_TIMEOUT > 0);

    mode_t            mode_q;
    astate_t          astate_q;
    logic             turn_right;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] man_cnt;
    logic [CNT_W-1:0] deb_cnt;
    logic             sync_q1;
    logic             sync_q2;
    logic             cmd_known;
    logic             cmd_take;

    assign mode       = mode_q;
    assign auto_state = astate_q;

    assign cmd_known = (cmd_data == CMD_LEFT) || (cmd_data == CMD_RIGHT) ||
                       (cmd_data == CMD_STOP) || (cmd_data == CMD_AUTO)  ||
                       (cmd_data == CMD_DOWN) || (cmd_data == CMD_UP);

    // AUTO while already in AUTO is not a takeover, so the FSM keeps running.
    assign cmd_take = cmd_valid && cmd_known &&
                      !((cmd_data == CMD_AUTO) && (mode_q == M_AUTO));

    // Synchronise the raw sensor, then require a run of highs before flagging wall.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            deb_cnt <= '0;
            wall    <= 1'b0;
        end else begin
            sync_q1 <= is_wall_raw;
            sync_q2 <= sync_q1;
            if (!sync_q2) begin
                deb_cnt <= '0;
                wall    <= 1'b0;
            end else if (deb_cnt == DEB_LAST) begin
                wall    <= 1'b1;
            end else begin
                deb_cnt <= deb_cnt + CNT_ONE;
            end
        end
    end

    // Quiet-time counter for the manual failsafe; any received byte restarts it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            man_cnt <= '0;
        end else if (cmd_valid || (mode_q != M_MANUAL) || (man_cnt == MAN_LAST)) begin
            man_cnt <= '0;
        end else begin
            man_cnt <= man_cnt + CNT_ONE;
        end
    end

    // Mode register, auto-avoidance FSM and registered motion outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mode_q     <= M_IDLE;
            astate_q   <= A_FWD;
            turn_right <= 1'b0;
            cnt        <= '0;
            cmd_err    <= 1'b0;
            {motor_en, motor_dir_l, motor_dir_r} <= MOT_STOP;
        end else begin
            cmd_err <= cmd_valid && !cmd_known;
            if (cmd_take) begin
                astate_q <= A_FWD;
                cnt      <= '0;
                if (cmd_data == CMD_STOP) begin
                    mode_q <= M_IDLE;
                    {motor_en, motor_dir_l, motor_dir_r} <= MOT_STOP;
                end else if (cmd_data == CMD_AUTO) begin
                    mode_q <= M_AUTO;
                    {motor_en, motor_dir_l, motor_dir_r} <= MOT_FWD;
                end else begin
                    mode_q <= M_MANUAL;
                    if (cmd_data == CMD_UP)
                        {motor_en, motor_dir_l, motor_dir_r} <= MOT_FWD;
                    else if (cmd_data == CMD_DOWN)
                        {motor_en, motor_dir_l, motor_dir_r} <= MOT_BACK;
                    else if (cmd_data == CMD_LEFT)
                        {motor_en, motor_dir_l, motor_dir_r} <= MOT_LEFT;
                    else
                        {motor_en, motor_dir_l, motor_dir_r} <= MOT_RIGHT;
                end
            end else begin
                case (mode_q)
                    M_AUTO: begin
                        case (astate_q)
                            A_FWD: begin
                                if (wall) begin
                                    astate_q <= A_BACK;
                                    cnt      <= '0;
                                    {motor_en, motor_dir_l, motor_dir_r} <= MOT_BACK;
                                end
                            end
                            A_BACK: begin
                                if (cnt == BACK_LAST) begin
                                    astate_q <= A_TURN;
                                    cnt      <= '0;
                                    {motor_en, motor_dir_l, motor_dir_r} <=
                                        turn_right ? MOT_RIGHT : MOT_LEFT;
                                end else begin
                                    cnt <= cnt + CNT_ONE;
                                end
                            end
                            A_TURN: begin
                                if (cnt == TURN_LAST) begin
                                    astate_q <= A_FWD;
                                    cnt      <= '0;
                                    {motor_en, motor_dir_l, motor_dir_r} <= MOT_FWD;
                                    if (ALT_TURN != 0)
                                        turn_right <= !turn_right;
                                end else begin
                                    cnt <= cnt + CNT_ONE;
                                end
                            end
                            default: begin
                                astate_q <= A_FWD;
                                cnt      <= '0;
                                {motor_en, motor_dir_l, motor_dir_r} <= MOT_FWD;
                            end
                        endcase
                    end
                    M_MANUAL: begin
                        if (TIMEOUT_EN && !cmd_valid && (man_cnt == MAN_LAST)) begin
                            mode_q <= M_IDLE;
                            {motor_en, motor_dir_l, motor_dir_r} <= MOT_STOP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_drive_mode_ctrl.sv
// Bench for drive_mode_ctrl: directed stimulus with literal expectations plus
// an elapsed-time reference model compared against the outputs every cycle.
module tb_drive_mode_ctrl;

    localparam int BACK = 10;
    localparam int TURN = 6;
    localparam int WD   = 3;
    localparam int TO   = 20;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       is_wall_raw;
    logic       motor_en, motor_dir_l, motor_dir_r;
    logic [1:0] mode, auto_state;
    logic       wall, cmd_err;

    int total = 0;
    int bad   = 0;

    drive_mode_ctrl #(
        .CNT_W(28), .BACK_CYCLES(BACK), .TURN_CYCLES(TURN),
        .WALL_DEBOUNCE(WD), .MANUAL_TIMEOUT(TO), .ALT_TURN(1)
    ) dut (
        .Clk(Clk), .Rst(Rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .is_wall_raw(is_wall_raw), .motor_en(motor_en), .motor_dir_l(motor_dir_l),
        .motor_dir_r(motor_dir_r), .mode(mode), .auto_state(auto_state),
        .wall(wall), .cmd_err(cmd_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] mot();
        return {motor_en, motor_dir_l, motor_dir_r};
    endfunction

    // ---------------- reference model ----------------
    bit         m_ok = 0;
    int         k;
    int         m_mode;
    logic [2:0] m_motion;
    bit         m_side;      // 1 = next turn goes right
    int         m_start;     // edge at which avoidance began, -1 when driving forward
    int         m_quiet;
    bit         m_wall;
    bit         m_err;
    bit         rh [WD+2];   // rh[j] = raw sampled j edges ago

    function automatic logic [2:0] exp_motion();
        if (m_mode == 0) return 3'b011;
        if (m_mode == 1) return m_motion;
        if (m_start < 0) return 3'b101;
        if (k - m_start < BACK) return 3'b110;
        return m_side ? 3'b111 : 3'b100;
    endfunction

    function automatic logic [1:0] exp_auto();
        if (m_mode != 2 || m_start < 0) return 2'd0;
        return (k - m_start < BACK) ? 2'd1 : 2'd2;
    endfunction

    always @(posedge Clk) begin
        bit wall_seen;
        bit took;
        if (Rst) begin
            m_ok = 1; k = 0; m_mode = 0; m_motion = 3'b011; m_side = 0;
            m_start = -1; m_quiet = 0; m_wall = 0; m_err = 0;
            foreach (rh[i]) rh[i] = 0;
        end else begin
            wall_seen = m_wall;
            k++;
            for (int i = WD + 1; i > 0; i--) rh[i] = rh[i-1];
            rh[0] = is_wall_raw;
            m_wall = 1;
            for (int i = 2; i <= WD + 1; i++) if (!rh[i]) m_wall = 0;
            took  = 0;
            m_err = 0;
            if (cmd_valid) begin
                m_quiet = 0;
                took = 1;
                case (cmd_data)
                    8'd9: begin m_mode = 1; m_motion = 3'b101; end
                    8'd7: begin m_mode = 1; m_motion = 3'b110; end
                    8'd3: begin m_mode = 1; m_motion = 3'b100; end
                    8'd4: begin m_mode = 1; m_motion = 3'b111; end
                    8'd5: m_mode = 0;
                    8'd6: if (m_mode != 2) m_mode = 2; else took = 0;
                    default: begin took = 0; m_err = 1; end
                endcase
                if (took) m_start = -1;
            end
            if (!took) begin
                if (m_mode == 2) begin
                    if (m_start < 0) begin
                        if (wall_seen) m_start = k;
                    end else if (k - m_start == BACK + TURN) begin
                        m_start = -1;
                        m_side  = !m_side;
                    end
                end else if (m_mode == 1 && !cmd_valid) begin
                    m_quiet++;
                    if (m_quiet == TO) m_mode = 0;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (m_ok) begin
            chk("model_motion", {5'd0, mot()}, {5'd0, exp_motion()});
            chk("model_mode", {6'd0, mode}, 8'(m_mode));
            chk("model_auto", {6'd0, auto_state}, {6'd0, exp_auto()});
            chk("model_wall", {7'd0, wall}, {7'd0, m_wall});
            chk("model_err", {7'd0, cmd_err}, {7'd0, m_err});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cmd_data  = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 8'd0;
    endtask

    task automatic wait_state(input logic [1:0] st, input string nm);
        int n = 0;
        while (auto_state !== st && n < 200) begin
            tick();
            n++;
        end
        chk(nm, {6'd0, auto_state}, {6'd0, st});
    endtask

    task automatic measure(input logic [1:0] st, output int n);
        n = 0;
        while (auto_state === st && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic avoid_to(input logic [1:0] st);
        is_wall_raw = 1'b1;
        wait_state(2'd1, "reach_back");
        is_wall_raw = 1'b0;
        if (st == 2'd2) wait_state(2'd2, "reach_turn");
    endtask

    task automatic pulse(input int len, output int highs);
        highs = 0;
        is_wall_raw = 1'b1;
        for (int i = 0; i < len; i++) begin
            tick();
            if (wall) highs++;
        end
        is_wall_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wall) highs++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_motion"}, {5'd0, mot()}, 8'h03);
        chk({tag, "_mode"}, {6'd0, mode}, 8'd0);
        chk({tag, "_auto"}, {6'd0, auto_state}, 8'd0);
        chk({tag, "_wall"}, {7'd0, wall}, 8'd0);
        chk({tag, "_err"}, {7'd0, cmd_err}, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int h;
        logic [2:0] saved;
        Rst = 1'b1; cmd_data = 8'd0; cmd_valid = 1'b0; is_wall_raw = 1'b0;
        tick(); tick();
        Rst = 1'b0;
        chk_reset("rst");

        // manual commands
        send(8'd9); chk("up_motion", {5'd0, mot()}, 8'h05); chk("up_mode", {6'd0, mode}, 8'd1);
        send(8'd3); chk("left_motion", {5'd0, mot()}, 8'h04);
        send(8'd4); chk("right_motion", {5'd0, mot()}, 8'h07);
        send(8'd7); chk("down_motion", {5'd0, mot()}, 8'h06);
        send(8'd5); chk("stop_motion", {5'd0, mot()}, 8'h03); chk("stop_mode", {6'd0, mode}, 8'd0);

        // auto avoidance with wall latency and phase lengths
        send(8'd6);
        chk("auto_mode", {6'd0, mode}, 8'd2);
        chk("auto_fwd", {5'd0, mot()}, 8'h05);
        is_wall_raw = 1'b1;
        repeat (4) tick();
        chk("wall_early", {7'd0, wall}, 8'd0);
        tick();
        chk("wall_rise", {7'd0, wall}, 8'd1);
        chk("still_fwd", {6'd0, auto_state}, 8'd0);
        tick();
        chk("enter_back", {6'd0, auto_state}, 8'd1);
        is_wall_raw = 1'b0;
        measure(2'd1, n);
        chk("back_len", 8'(n), 8'd10);
        chk("turn1_left", {5'd0, mot()}, 8'h04);
        measure(2'd2, n);
        chk("turn_len", 8'(n), 8'd6);
        chk("after_turn", {5'd0, mot()}, 8'h05);
        avoid_to(2'd2);
        chk("turn2_right", {5'd0, mot()}, 8'h07);
        wait_state(2'd0, "turn2_done");

        // AUTO during A_BACK is ignored; UP during A_TURN takes over
        avoid_to(2'd1);
        tick(); tick();
        send(8'd6);
        chk("auto_in_back", {6'd0, auto_state}, 8'd1);
        measure(2'd1, n);
        chk("back_len_kept", 8'(3 + n), 8'd10);
        tick();
        send(8'd9);
        chk("up_in_turn_mode", {6'd0, mode}, 8'd1);
        chk("up_in_turn_auto", {6'd0, auto_state}, 8'd0);
        chk("up_in_turn_motion", {5'd0, mot()}, 8'h05);

        // debounce
        send(8'd5);
        pulse(2, h); chk("pulse2", 8'(h), 8'd0);
        pulse(3, h); chk("pulse3", 8'(h), 8'd1);
        pulse(5, h); chk("pulse5", 8'(h), 8'd3);

        // unknown code and manual timeout
        send(8'd9);
        saved = mot();
        send(8'h41);
        chk("err_pulse", {7'd0, cmd_err}, 8'd1);
        chk("err_motion", {5'd0, mot()}, {5'd0, saved});
        chk("err_mode", {6'd0, mode}, 8'd1);
        tick();
        chk("err_clear", {7'd0, cmd_err}, 8'd0);
        n = 0;
        while (mode === 2'd1 && n < 100) begin n++; tick(); end
        chk("timeout_len", 8'(1 + n), 8'd20);
        chk("timeout_en", {7'd0, motor_en}, 8'd0);
        send(8'd9);
        repeat (4) begin
            repeat (14) tick();
            send(8'd9);
        end
        repeat (14) tick();
        chk("keepalive_mode", {6'd0, mode}, 8'd1);

        // reset mid-avoidance
        send(8'd6);
        avoid_to(2'd2);
        wait_state(2'd0, "turn3_done");
        avoid_to(2'd2);
        chk("turn4_right", {5'd0, mot()}, 8'h07);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk_reset("midrst");
        send(8'd6);
        chk("restart_auto", {6'd0, auto_state}, 8'd0);
        chk("restart_mode", {6'd0, mode}, 8'd2);
        avoid_to(2'd2);
        chk("restart_left", {5'd0, mot()}, 8'h04);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
